// File: rtl/updown_counter_param_if.sv
// Control/status bundle for updown_counter_param: the master drives load/count controls, the slave returns count and flags.
interface updown_counter_param_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic [WIDTH-1:0] data;
   logic             en;
   logic             ud;
   logic [WIDTH-1:0] step;
   logic             sat;
   logic [WIDTH-1:0] count;
   logic             ovf;
   logic             unf;
   logic             tc;

   modport master (
      output load, data, en, ud, step, sat,
      input  count, ovf, unf, tc
   );

   modport slave (
      input  load, data, en, ud, step, sat,
      output count, ovf, unf, tc
   );
endinterface

// File: rtl/updown_counter_param.sv
// Modulo-(MAX_VAL+1) up/down counter with clamped load, variable step and registered ovf/unf pulses; 1-cycle latency.
// Define UDCNT_SATURATE_EN to let the sat input choose saturate instead of wrap; otherwise the counter always wraps.
module updown_counter_param #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 2**WIDTH-1
) (
   input logic                  clk,
   input logic                  reset,
   updown_counter_param_if.slave bus
);
   // All arithmetic is one bit wider than the count so count+step never truncates before the compare.
   localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   MOD_W   = MAX_W + (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_CNT = MAX_W[WIDTH-1:0];

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             sat_mode;
   logic [WIDTH:0]   cnt_x, step_x, s_x, sum_x;

`ifdef UDCNT_SATURATE_EN
   assign sat_mode = bus.sat;
`else
   assign sat_mode = 1'b0;
`endif

   always_comb begin
      cnt_x   = {1'b0, count_q};
      step_x  = {1'b0, bus.step};
      s_x     = (step_x > MAX_W) ? MAX_W : step_x;
      sum_x   = cnt_x + s_x;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (bus.load) begin
         count_d = ({1'b0, bus.data} > MAX_W) ? MAX_CNT : bus.data;
      end else if (bus.en && (s_x != '0)) begin
         if (bus.ud) begin
            if (sum_x > MAX_W) begin
               ovf_d   = 1'b1;
               count_d = sat_mode ? MAX_CNT : WIDTH'(sum_x - MOD_W);
            end else begin
               count_d = sum_x[WIDTH-1:0];
            end
         end else begin
            if (cnt_x >= s_x) begin
               count_d = WIDTH'(cnt_x - s_x);
            end else begin
               unf_d   = 1'b1;
               count_d = sat_mode ? '0 : WIDTH'(cnt_x + MOD_W - s_x);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
   assign bus.tc    = (bus.ud & (count_q == MAX_CNT)) | (~bus.ud & (count_q == '0));
endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param (WIDTH=4, MAX_VAL=9): directed scenarios followed by random traffic.
module tb_updown_counter_param;
   localparam int W   = 4;
   localparam int MAX = 9;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   updown_counter_param_if #(.WIDTH(W)) bus ();

   updown_counter_param #(.WIDTH(W), .MAX_VAL(MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int c;
      bit o;
      bit u;
   } exp_t;

   exp_t exp_q[$];
   int   vectors   = 0;
   int   miscompares = 0;
   int   m_count   = 0;
   bit   m_known   = 0;
   bit   sat_honoured;

   // Reference model: counter value as a plain integer in 0..MAX.
   task automatic apply(input bit r, input bit l, input int d, input bit e,
                        input bit u, input int st, input bit sa);
      exp_t x;
      int   s;
      bit   do_sat;
      @(negedge clk);
      reset    = r;
      bus.load = l;
      bus.data = W'(d);
      bus.en   = e;
      bus.ud   = u;
      bus.step = W'(st);
      bus.sat  = sa;
      #1;
      if (m_known) begin
         vectors++;
         if (bus.tc !== ((u && m_count == MAX) || (!u && m_count == 0))) begin
            miscompares++;
            $display("FAIL tc: got %b, want %b (count=%0d ud=%b)", bus.tc,
                     (u && m_count == MAX) || (!u && m_count == 0), m_count, u);
         end
      end
      do_sat = sa && sat_honoured;
      x.o = 0;
      x.u = 0;
      if (r) begin
         m_count = 0;
         m_known = 1;
      end else if (l) begin
         m_count = (d > MAX) ? MAX : d;
      end else if (e) begin
         s = (st > MAX) ? MAX : st;
         if (s != 0) begin
            if (u) begin
               if (m_count + s > MAX) begin
                  x.o = 1;
                  m_count = do_sat ? MAX : (m_count + s) % (MAX + 1);
               end else m_count = m_count + s;
            end else begin
               if (m_count < s) begin
                  x.u = 1;
                  m_count = do_sat ? 0 : m_count + (MAX + 1) - s;
               end else m_count = m_count - s;
            end
         end
      end
      x.c = m_count;
      if (m_known) exp_q.push_back(x);
   endtask

   // Monitor: every edge where an expectation is pending, compare registered outputs.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (bus.count !== W'(x.c) || bus.ovf !== x.o || bus.unf !== x.u) begin
               miscompares++;
               $display("FAIL outputs @%0t: got count=%0d ovf=%b unf=%b, want count=%0d ovf=%b unf=%b",
                        $time, bus.count, bus.ovf, bus.unf, x.c, x.o, x.u);
            end
         end
      end
   end

   initial begin
`ifdef UDCNT_SATURATE_EN
      sat_honoured = 1;
`else
      sat_honoured = 0;
`endif
      reset = 1; bus.load = 0; bus.data = '0; bus.en = 0; bus.ud = 1; bus.step = '0; bus.sat = 0;

      // reset then clamped load
      apply(1, 0, 0, 0, 1, 0, 0);
      apply(0, 1, 13, 0, 1, 0, 0);
      // up wrap 8+3 -> 1 with ovf, then hold clears the flag
      apply(0, 1, 8, 0, 1, 0, 0);
      apply(0, 0, 0, 1, 1, 3, 0);
      apply(0, 0, 0, 0, 1, 3, 0);
      // down wrap 1-2 -> 9 with unf, then 7
      apply(0, 1, 1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 0, 2, 0);
      apply(0, 0, 0, 1, 0, 2, 0);
      // saturate (or wrap when compiled out), then saturated hold
      apply(0, 1, 7, 0, 1, 0, 0);
      apply(0, 0, 0, 1, 1, 5, 1);
      apply(0, 0, 0, 1, 1, 5, 1);
      apply(0, 0, 0, 1, 1, 5, 1);
      // saturate down at zero
      apply(0, 1, 1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 0, 15, 1);
      apply(0, 0, 0, 1, 0, 15, 1);
      // priority: reset over load/en, then load over en
      apply(1, 1, 6, 1, 1, 2, 0);
      apply(0, 1, 4, 1, 1, 2, 0);
      // step 0 holds; en low with ud toggling checks tc
      apply(0, 0, 0, 1, 1, 0, 0);
      apply(0, 1, 9, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, i[0], 3, 0);
      apply(0, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, i[0], 3, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 15), $urandom_range(0, 1) == 1);
      end

      @(negedge clk);
      bus.en = 0; bus.load = 0;
      repeat (2) @(posedge clk);
      #2;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
